// File: rtl/reg_file_wr_demux.sv
// 32 x 32-bit architectural register bank: one-hot write demux, one write port,
// two combinational read ports with write-first bypass, plus write tracking.
module reg_file_wr_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic [(2**ADDR_W)-1:0] wr_onehot_q,
  output logic [15:0]            wr_count_q
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  dec;

  always_comb begin
    dec = '0;
    if (wr_en) dec[wr_addr] = 1'b1;
  end

  // Register update stage: reset clears the bank and tracking, and beats any write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_onehot_q <= '0;
      wr_count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dec[i]) regs[i] <= wr_data;
      end
      wr_onehot_q <= dec;
      if (wr_en) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Write-first bypass stays live during reset since it is purely combinational
  assign rd_data_a = (wr_en && (rd_addr_a == wr_addr)) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (wr_en && (rd_addr_b == wr_addr)) ? wr_data : regs[rd_addr_b];

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Randomized self-checking bench for reg_file_wr_demux against an array-based
// reference model of the register bank, write image and write counter.
module tb_reg_file_wr_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] wr_onehot_q;
  logic [15:0] wr_count_q;

  reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_onehot_q(wr_onehot_q),
    .wr_count_q (wr_count_q)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] onehot_exp;
  int          count_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational reads before the edge,
  // advance the model at the edge, then check the registered outputs.
  task automatic cyc(input logic rv, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra,
                     input logic [4:0] rb, input bit chk_rd);
    logic [31:0] ea, eb;
    rst = rv; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    #3;
    if (chk_rd) begin
      ea = (we && ra == wa) ? wd : mem[ra];
      eb = (we && rb == wa) ? wd : mem[rb];
      chk("rd_data_a", rd_data_a, ea);
      chk("rd_data_b", rd_data_b, eb);
    end
    @(posedge clk);
    if (!rv) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      onehot_exp = 32'h0;
      count_exp  = 0;
    end else if (we) begin
      mem[wa]    = wd;
      onehot_exp = 32'h1 << wa;
      count_exp  = (count_exp + 1) % 65536;
    end else begin
      onehot_exp = 32'h0;
    end
    #1;
    chk("wr_onehot_q", wr_onehot_q, onehot_exp);
    chk("wr_count_q", {16'h0, wr_count_q}, count_exp[31:0]);
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    onehot_exp = 32'h0;
    count_exp  = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    #1;

    // Reset for two cycles, then sweep every address on both ports
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b0, 5'd0, 32'h0, i[4:0], 5'(31 - i), 1'b1);

    // Write then read
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1);
    chk("onehot_addr5", wr_onehot_q, 32'h00000020);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1);

    // Bypass on both ports at address 31, then read the stored value
    cyc(1'b1, 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd5, 1'b1);

    // Reset beats a simultaneous write; bypass still visible during reset
    cyc(1'b1, 1'b1, 5'd3, 32'h0BADF00D, 5'd3, 5'd3, 1'b1);
    cyc(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd31, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b1);

    // Back-to-back writes to the same address
    cyc(1'b1, 1'b1, 5'd7, 32'hA, 5'd7, 5'd0, 1'b1);
    chk("onehot_b2b_1", wr_onehot_q, 32'h80);
    cyc(1'b1, 1'b1, 5'd7, 32'hB, 5'd7, 5'd7, 1'b1);
    chk("onehot_b2b_2", wr_onehot_q, 32'h80);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1);
    chk("onehot_idle", wr_onehot_q, 32'h0);
    chk("count_b2b", {16'h0, wr_count_q}, 32'd2);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
          5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'b1);

    // Counter wrap: 65536 writes to address 1 from a fresh reset
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    d = 32'h0;
    for (int n = 0; n < 65536; n++) begin
      d = $urandom;
      cyc(1'b1, 1'b1, 5'd1, d, 5'd1, 5'($urandom), 1'b1);
    end
    chk("count_wrap", {16'h0, wr_count_q}, 32'h0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 1'b1);
    chk("reg1_last", rd_data_a, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_demux.md
Name: reg_file_wr_demux

Overview:
- Architectural register bank for the KGP-RISC datapath: 32 x 32-bit registers with one write port and two read ports.
- Sits downstream of the 5-bit destination-register select path. The selected 5-bit write address is demultiplexed into a one-hot write-enable vector, and the addressed register is updated on the clock edge.
- Two source operands are read for the decode/execute stage.
- Provides write-first bypass so a same-cycle write is visible on the read ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- wr_en  input  1  write request for the current cycle.
- wr_addr  input  5  destination register address (output of the destination-select mux).
- wr_data  input  32  write-back data.
- rd_addr_a  input  5  source register A address.
- rd_addr_b  input  5  source register B address.
- rd_data_a  output  32  register A contents, combinational, with bypass.
- rd_data_b  output  32  register B contents, combinational, with bypass.
- wr_onehot_q  output  32  registered one-hot decode of the last accepted write; all zero if no write occurred in the previous cycle.
- wr_count_q  output  16  count of accepted writes since reset; wraps modulo 2**16.

Behaviour:
- Clock and reset
  - Single clock domain; reset is synchronous, active-low.
  - When rst == 0 at a rising edge: all 32 registers become 0, wr_onehot_q becomes 0, wr_count_q becomes 0.
  - Reset has priority over a simultaneous wr_en; that write is discarded.
- Write demux
  - dec[i] = wr_en & (wr_addr == i) for i in 0..31.
  - Exactly one bit of dec is set when wr_en = 1; none are set when wr_en = 0.
- Write
  - On a rising edge with rst == 1 and dec[i] == 1: reg[i] <= wr_data.
  - All 32 registers, including register 0, are writable; there is no hardwired zero.
  - Write latency is 1 cycle.
- Read
  - rd_data_x = reg[rd_addr_x] when not bypassed.
  - Combinational, zero-cycle latency.
- Bypass (write-first)
  - If wr_en == 1 and rd_addr_x == wr_addr in the same cycle, rd_data_x = wr_data.
  - Applies independently to ports A and B; both ports may bypass simultaneously.
  - Bypass is still active while rst == 0, because it is combinational. The stored value remains 0 after the reset edge.
- wr_onehot_q
  - On each non-reset edge, wr_onehot_q <= dec. This is a 1-cycle-delayed one-hot image of the write.
- wr_count_q
  - On each non-reset edge with wr_en == 1: wr_count_q <= wr_count_q + 1.
  - Increments even when the same value is rewritten.
  - Wraps 0xFFFF -> 0x0000 with no flag.
- Boundaries
  - Address 31 (the link-register target of the select mux) behaves identically to any other address.
  - Back-to-back writes to the same address: the last write wins; intermediate values are visible only through bypass in their own cycle.
  - Reset asserted mid-sequence clears everything on that edge; reads in the following cycle return 0.
- No X propagation
  - Out-of-range addresses are impossible because the address width equals log2(depth).

Test Plan:
1. Reset then read: hold rst = 0 for 2 cycles, release, read addresses 0..31 on both ports -> all rd_data = 0x00000000, wr_onehot_q = 0, wr_count_q = 0.
2. Write then read: write 0xDEADBEEF to addr 5, next cycle rd_addr_a = 5, rd_addr_b = 6 -> rd_data_a = 0xDEADBEEF, rd_data_b = 0, wr_onehot_q = 0x00000020, wr_count_q = 1.
3. Bypass: wr_en = 1, wr_addr = 31, wr_data = 0x12345678, rd_addr_a = rd_addr_b = 31 in the same cycle -> both ports read 0x12345678 before the edge, and reg[31] holds it after the edge.
4. Reset beats write: rst = 0 with wr_en = 1, wr_addr = 3, wr_data = 0xFFFFFFFF -> after the edge reg[3] = 0 and wr_count_q = 0.
5. Back-to-back same address: write 0xA to addr 7, then 0xB to addr 7, then idle -> reg[7] = 0xB, wr_onehot_q = 0x80 then 0x80 then 0, wr_count_q = 2.
6. Counter wrap: perform 65536 writes to addr 1 -> wr_count_q returns to 0x0000, and reg[1] equals the last written value.
